// File: rtl/quick_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quick_uart_pkg
// Description : Shared types and the parity helper for the quick_uart
//               receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package quick_uart_pkg;

  // Parity mode selected by the receiver's PARITY parameter.
  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  // Receiver frame states.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Widest supported data word; narrower words are zero-extended, which
  // leaves their XOR unchanged.
  localparam int c_MAX_DATA_BITS = 9;

  // Parity bit the transmitter should have sent for this data word.
  function automatic logic parity_calc(input logic [c_MAX_DATA_BITS-1:0] data,
                                       input parity_e mode);
    logic w_x;
    w_x = ^data;
    return (mode == PARITY_ODD) ? ~w_x : w_x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quick_uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : quick_uart_sync
// Description : Two-flop synchronizer for an asynchronous single-bit input,
//               with a selectable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module quick_uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage metastability filter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/quick_uart_rx_checked.sv
`default_nettype none
// ============================================================================
// Module      : quick_uart_rx_checked
// Description : UART receiver with majority-of-3 mid-bit sampling, optional
//               parity, framing/break detection and a one-deep valid/ready
//               output register with a sticky data-dropped flag.
// Revision    : 1.0 - initial release
// ============================================================================
module quick_uart_rx_checked
  import quick_uart_pkg::*;
#(
  parameter int DIV       = 5,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 busy_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 framing_err_o,
  output logic                 break_o,
  output logic                 data_dropped_o
);

  localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_CW-1:0] c_MID_M1   = c_CW'(DIV / 2 - 1);
  localparam logic [c_CW-1:0] c_MID      = c_CW'(DIV / 2);
  localparam logic [c_CW-1:0] c_MID_P1   = c_CW'(DIV / 2 + 1);
  localparam logic [c_CW-1:0] c_LAST     = c_CW'(DIV - 1);
  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DATA_BITS - 1);
  localparam parity_e         c_MODE     = parity_e'(PARITY[1:0]);
  localparam logic            c_HAS_PAR  = (PARITY != 0);

  logic                 w_rxs;
  logic                 r_rxs_prev;
  rx_state_e            r_state;
  logic [c_CW-1:0]      r_cnt;
  logic [c_BW-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_s0;
  logic                 r_s1;
  logic                 r_busy;

  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_par_err;
  logic                 r_framing;
  logic                 r_break;
  logic                 r_dropped;

  quick_uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (rx_i),
    .o_q    (w_rxs)
  );

  // Bit decision: majority of the two stored samples and the current one.
  logic w_tick_dec;
  logic w_wrap;
  logic w_bit;
  assign w_tick_dec = (r_cnt == c_MID_P1);
  assign w_wrap     = (r_cnt == c_LAST);
  assign w_bit      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

  // Frame-level results, meaningful on the stop-bit decision cycle.
  logic w_complete;
  logic w_framing;
  logic w_break;
  logic w_par_err;
  assign w_complete = (r_state == RX_STOP) && w_tick_dec;
  assign w_framing  = ~w_bit;
  assign w_break    = w_framing && (r_shift == '0) && (!c_HAS_PAR || !r_par_bit);
  assign w_par_err  = c_HAS_PAR &&
                      (parity_calc(c_MAX_DATA_BITS'(r_shift), c_MODE) != r_par_bit);

  // Receive FSM: start detection, bit timing, sampling and data shifting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_rxs_prev <= w_rxs;
      if (r_cnt == c_MID_M1) r_s0 <= w_rxs;
      if (r_cnt == c_MID)    r_s1 <= w_rxs;
      r_cnt <= w_wrap ? '0 : r_cnt + c_CW'(1);
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_rxs_prev && !w_rxs) begin
            r_state <= RX_START;
            r_busy  <= 1'b1;
          end
        end
        RX_START: begin
          if (w_tick_dec && w_bit) begin
            r_state <= RX_IDLE;
            r_busy  <= 1'b0;
          end else if (w_wrap) begin
            r_state   <= RX_DATA;
            r_bit_idx <= '0;
          end
        end
        RX_DATA: begin
          if (w_tick_dec) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
          if (w_wrap) begin
            if (r_bit_idx == c_LAST_BIT) r_state <= c_HAS_PAR ? RX_PARITY : RX_STOP;
            else                         r_bit_idx <= r_bit_idx + c_BW'(1);
          end
        end
        RX_PARITY: begin
          if (w_tick_dec) r_par_bit <= w_bit;
          if (w_wrap)     r_state   <= RX_STOP;
        end
        RX_STOP: begin
          // A good stop bit returns to IDLE early to tolerate baud mismatch.
          if (w_tick_dec) begin
            if (w_bit) begin
              r_state <= RX_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          r_cnt <= '0;
          if (w_rxs) begin
            r_state <= RX_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= RX_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // One-deep output register; a frame arriving while a word is stalled is
  // discarded and only recorded in the sticky drop flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_par_err <= 1'b0;
      r_framing <= 1'b0;
      r_break   <= 1'b0;
      r_dropped <= 1'b0;
    end else if (w_complete) begin
      if (r_valid && !ready_i) begin
        r_dropped <= 1'b1;
      end else begin
        r_valid   <= 1'b1;
        r_data    <= r_shift;
        r_par_err <= w_par_err;
        r_framing <= w_framing;
        r_break   <= w_break;
        r_dropped <= 1'b0;
      end
    end else if (r_valid && ready_i) begin
      r_valid   <= 1'b0;
      r_dropped <= 1'b0;
    end
  end

  assign busy_o         = r_busy;
  assign valid_o        = r_valid;
  assign data_o         = r_data;
  assign parity_err_o   = r_par_err;
  assign framing_err_o  = r_framing;
  assign break_o        = r_break;
  assign data_dropped_o = r_dropped;

endmodule
`default_nettype wire
